// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS decode/execute slice.
// Contents:
//   - opcode constants (instruction[31:26])
//   - R-type funct constants (instruction[5:0])
//   - aluop class encodings
//   - 4-bit ALU control codes
//   - the registered control-bundle type
//   - a sign-extension helper
package mips_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct field
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // aluop classes produced by main control
    localparam logic [1:0] ALUOP_ADD   = 2'b00;   // loads/stores/addi
    localparam logic [1:0] ALUOP_SUB   = 2'b01;   // branch compare
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;   // R-type, look at funct
    localparam logic [1:0] ALUOP_NONE  = 2'b11;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // Control signals that leave the block through the ID/EX register.
    typedef struct packed {
        logic       regdst;
        logic       branch_eq;
        logic       branch_ne;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_alu32.sv
// Combinational ALU with zero flag.
// Ports:
//   ctl    in  4  ALU control code (ALU_* in mips_pkg)
//   a, b   in  W  operands
//   result out W  operation result (0 for unused codes)
//   zero   out 1  result == 0
module mips_alu32
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   ctl,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         zero
);

    always_comb begin
        result = '0;
        case (ctl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            // Signed compare rather than the sign of a-b, so it stays
            // correct when the subtraction would overflow.
            ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// Decode-and-execute slice forming the ID/EX pipeline boundary.
// Main control and ALU control are decoded here; the ALU itself lives in
// mips_alu32. Every output is registered once.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   hold             freeze all output registers (stall)
//   clear            zero all output registers (bubble); beats hold
//   opcode, funct    instruction fields
//   rs_data, rt_data register operands
//   imm              16-bit immediate, sign-extended for operand B
//   regdst..jump     registered main-control outputs
//   aluop, aluctl    registered ALU class / decoded operation
//   alu_result, zero registered ALU result and zero flag
module mips_decode_exec
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    input  logic [W-1:0] rs_data,
    input  logic [W-1:0] rt_data,
    input  logic [15:0]  imm,
    output logic         regdst,
    output logic         branch_eq,
    output logic         branch_ne,
    output logic         memread,
    output logic         memwrite,
    output logic         memtoreg,
    output logic         regwrite,
    output logic         jump,
    output logic [1:0]   aluop,
    output logic [3:0]   aluctl,
    output logic [W-1:0] alu_result,
    output logic         zero
);

    ctrl_t        ctrl;
    logic         alusrc;
    logic [3:0]   ctl;
    logic [W-1:0] operand_b;
    logic [W-1:0] result;
    logic         result_zero;

    ctrl_t        ctrl_d,   ctrl_q;
    logic [3:0]   aluctl_d, aluctl_q;
    logic [W-1:0] result_d, result_q;
    logic         zero_d,   zero_q;

    // Main control
    always_comb begin
        ctrl   = '0;
        alusrc = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.aluop    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
                alusrc        = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                alusrc        = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch_eq = 1'b1;
                ctrl.aluop     = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.aluop     = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl.regwrite = 1'b1;
                alusrc        = 1'b1;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // ALU control
    always_comb begin
        ctl = ALU_AND;
        case (ctrl.aluop)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  ctl = ALU_ADD;
                    FN_SUB:  ctl = ALU_SUB;
                    FN_AND:  ctl = ALU_AND;
                    FN_OR:   ctl = ALU_OR;
                    FN_XOR:  ctl = ALU_XOR;
                    FN_NOR:  ctl = ALU_NOR;
                    FN_SLT:  ctl = ALU_SLT;
                    default: ctl = ALU_AND;
                endcase
            end
            default: ctl = ALU_AND;
        endcase
    end

    assign operand_b = alusrc ? {{(W-16){imm[15]}}, imm} : rt_data;

    mips_alu32 #(.W(W)) u_alu (
        .ctl    (ctl),
        .a      (rs_data),
        .b      (operand_b),
        .result (result),
        .zero   (result_zero)
    );

    // Register next-state: clear beats hold; rst is applied in the flop.
    always_comb begin
        ctrl_d   = ctrl_q;
        aluctl_d = aluctl_q;
        result_d = result_q;
        zero_d   = zero_q;
        if (clear) begin
            ctrl_d   = '0;
            aluctl_d = '0;
            result_d = '0;
            zero_d   = 1'b0;
        end else if (!hold) begin
            ctrl_d   = ctrl;
            aluctl_d = ctl;
            result_d = result;
            zero_d   = result_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            aluctl_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            aluctl_q <= aluctl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign regdst     = ctrl_q.regdst;
    assign branch_eq  = ctrl_q.branch_eq;
    assign branch_ne  = ctrl_q.branch_ne;
    assign memread    = ctrl_q.memread;
    assign memwrite   = ctrl_q.memwrite;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regwrite   = ctrl_q.regwrite;
    assign jump       = ctrl_q.jump;
    assign aluop      = ctrl_q.aluop;
    assign aluctl     = aluctl_q;
    assign alu_result = result_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Bench for mips_decode_exec: directed vector table, register-control
// sequences, and random instructions checked against a reference model.
module tb_mips_decode_exec;

    typedef struct packed {
        logic        regdst;
        logic        branch_eq;
        logic        branch_ne;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
        logic        regwrite;
        logic        jump;
        logic [1:0]  aluop;
        logic [3:0]  aluctl;
        logic [31:0] res;
        logic        zero;
    } outs_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        outs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, hold, clear;
    logic [5:0]  opcode, funct;
    logic [31:0] rs_data, rt_data;
    logic [15:0] imm;
    logic        regdst, branch_eq, branch_ne, memread, memwrite, memtoreg, regwrite, jump;
    logic [1:0]  aluop;
    logic [3:0]  aluctl;
    logic [31:0] alu_result;
    logic        zero;
    outs_t       got;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mips_decode_exec #(.W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .clear      (clear),
        .opcode     (opcode),
        .funct      (funct),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .imm        (imm),
        .regdst     (regdst),
        .branch_eq  (branch_eq),
        .branch_ne  (branch_ne),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .jump       (jump),
        .aluop      (aluop),
        .aluctl     (aluctl),
        .alu_result (alu_result),
        .zero       (zero)
    );

    assign got = '{regdst, branch_eq, branch_ne, memread, memwrite, memtoreg,
                   regwrite, jump, aluop, aluctl, alu_result, zero};

    // Reference model: instruction semantics computed directly.
    function automatic outs_t model(input logic [5:0] op, input logic [5:0] fn,
                                    input logic [31:0] a, input logic [31:0] rt,
                                    input logic [15:0] im);
        outs_t       o;
        logic [31:0] b;
        bit          use_imm;
        o       = '0;
        use_imm = 0;
        case (op)
            6'h00: begin o.regdst = 1; o.regwrite = 1; o.aluop = 2'd2; end
            6'h23: begin o.memread = 1; o.memtoreg = 1; o.regwrite = 1; use_imm = 1; end
            6'h2b: begin o.memwrite = 1; use_imm = 1; end
            6'h04: begin o.branch_eq = 1; o.aluop = 2'd1; end
            6'h05: begin o.branch_ne = 1; o.aluop = 2'd1; end
            6'h08: begin o.regwrite = 1; use_imm = 1; end
            6'h02: begin o.jump = 1; end
            default: ;
        endcase
        if (o.aluop == 2'd0)      o.aluctl = 4'd2;
        else if (o.aluop == 2'd1) o.aluctl = 4'd6;
        else begin
            case (fn)
                6'h20: o.aluctl = 4'd2;
                6'h22: o.aluctl = 4'd6;
                6'h25: o.aluctl = 4'd1;
                6'h26: o.aluctl = 4'd13;
                6'h27: o.aluctl = 4'd12;
                6'h2a: o.aluctl = 4'd7;
                default: o.aluctl = 4'd0;
            endcase
        end
        b = use_imm ? 32'(signed'(im)) : rt;
        case (o.aluctl)
            4'd0:  o.res = a & b;
            4'd1:  o.res = a | b;
            4'd13: o.res = a ^ b;
            4'd12: o.res = ~(a | b);
            4'd2:  o.res = a + b;
            4'd6:  o.res = a - b;
            4'd7:  o.res = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            default: o.res = 32'd0;
        endcase
        o.zero = (o.res == 32'd0);
        return o;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic [15:0] im);
        opcode = op; funct = fn; rs_data = a; rt_data = b; imm = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end else begin
            $display("ok   %s out=%h", name, got);
        end
    endtask

    vec_t  vecs[17];
    outs_t saved;

    initial begin
        // regdst,beq,bne,mr,mw,m2r,rw,j, aluop, aluctl, result, zero
        vecs[0]  = '{6'h00, 6'h20, 32'd5, 32'd7, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0010, 32'd12, 1'b0}};
        vecs[1]  = '{6'h23, 6'h00, 32'h100, 32'h55, 16'hFFFC,
                     '{0,0,0,1,0,1,1,0, 2'b00, 4'b0010, 32'hFC, 1'b0}};
        vecs[2]  = '{6'h04, 6'h00, 32'h1234, 32'h1234, 16'h0000,
                     '{0,1,0,0,0,0,0,0, 2'b01, 4'b0110, 32'h0, 1'b1}};
        vecs[3]  = '{6'h05, 6'h00, 32'd1, 32'd2, 16'h0000,
                     '{0,0,1,0,0,0,0,0, 2'b01, 4'b0110, 32'hFFFFFFFF, 1'b0}};
        vecs[4]  = '{6'h00, 6'h2a, 32'hFFFFFFFF, 32'd1, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0111, 32'd1, 1'b0}};
        vecs[5]  = '{6'h00, 6'h2a, 32'h80000000, 32'h7FFFFFFF, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0111, 32'd1, 1'b0}};
        vecs[6]  = '{6'h00, 6'h2a, 32'd1, 32'hFFFFFFFF, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0111, 32'd0, 1'b1}};
        vecs[7]  = '{6'h00, 6'h27, 32'd0, 32'd0, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b1100, 32'hFFFFFFFF, 1'b0}};
        vecs[8]  = '{6'h00, 6'h26, 32'hF0F0, 32'hFF00, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b1101, 32'h0FF0, 1'b0}};
        vecs[9]  = '{6'h3F, 6'h20, 32'd3, 32'd4, 16'h0000,
                     '{0,0,0,0,0,0,0,0, 2'b00, 4'b0010, 32'd7, 1'b0}};
        vecs[10] = '{6'h02, 6'h00, 32'd0, 32'd0, 16'h1234,
                     '{0,0,0,0,0,0,0,1, 2'b00, 4'b0010, 32'd0, 1'b1}};
        vecs[11] = '{6'h2b, 6'h00, 32'h1000, 32'h99, 16'h0010,
                     '{0,0,0,0,1,0,0,0, 2'b00, 4'b0010, 32'h1010, 1'b0}};
        vecs[12] = '{6'h08, 6'h00, 32'd5, 32'd100, 16'hFFFF,
                     '{0,0,0,0,0,0,1,0, 2'b00, 4'b0010, 32'd4, 1'b0}};
        vecs[13] = '{6'h00, 6'h22, 32'd3, 32'd3, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0110, 32'd0, 1'b1}};
        vecs[14] = '{6'h00, 6'h24, 32'hFF00FF00, 32'h0F0F0F0F, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0000, 32'h0F000F00, 1'b0}};
        vecs[15] = '{6'h00, 6'h25, 32'hF0, 32'h0F, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0001, 32'hFF, 1'b0}};
        vecs[16] = '{6'h00, 6'h00, 32'd5, 32'd7, 16'h0000,
                     '{1,0,0,0,0,0,1,0, 2'b10, 4'b0000, 32'd5, 1'b0}};

        // Reset state, with non-trivial inputs present
        rst = 1'b1; hold = 1'b0; clear = 1'b0;
        drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        tick();
        tick();
        check("reset", '0);
        rst = 1'b0;

        // Directed table
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].imm);
            tick();
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Hold two cycles while inputs change
        drive(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        tick();
        saved = model(6'h00, 6'h20, 32'd5, 32'd7, 16'h0);
        check("pre_hold", saved);
        hold = 1'b1;
        drive(6'h23, 6'h00, 32'h100, 32'h0, 16'hFFFC);
        tick();
        check("hold1", saved);
        drive(6'h04, 6'h00, 32'h1, 32'h1, 16'h0);
        tick();
        check("hold2", saved);
        hold = 1'b0;
        tick();
        check("hold_release", model(6'h04, 6'h00, 32'h1, 32'h1, 16'h0));

        // Clear together with hold: clear wins
        hold = 1'b1; clear = 1'b1;
        drive(6'h00, 6'h27, 32'd0, 32'd0, 16'h0);
        tick();
        check("clear_hold", '0);
        hold = 1'b0; clear = 1'b0;
        tick();
        check("after_clear", model(6'h00, 6'h27, 32'd0, 32'd0, 16'h0));

        // Clear alone
        clear = 1'b1;
        tick();
        check("clear", '0);
        clear = 1'b0;

        // Reset mid-stream
        drive(6'h23, 6'h00, 32'h200, 32'h0, 16'h0004);
        tick();
        check("pre_rst", model(6'h23, 6'h00, 32'h200, 32'h0, 16'h0004));
        rst = 1'b1;
        tick();
        check("rst_mid", '0);
        rst = 1'b0;

        // Random instructions, biased toward legal opcodes and functs
        for (int n = 0; n < 300; n++) begin
            logic [5:0]  op, fn;
            logic [31:0] a, b;
            logic [15:0] im;
            logic [5:0]  ops [8];
            logic [5:0]  fns [8];
            ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h02, 6'h00};
            fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h20};
            op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom);
            fn = ($urandom_range(0, 9) < 8) ? fns[$urandom_range(0, 7)] : 6'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
            im = 16'($urandom);
            drive(op, fn, a, b, im);
            hold  = ($urandom_range(0, 9) == 0);
            clear = ($urandom_range(0, 19) == 0);
            saved = clear ? outs_t'(0) : (hold ? got : model(op, fn, a, b, im));
            tick();
            check($sformatf("rnd%0d op=%h fn=%h h=%0d c=%0d", n, op, fn, hold, clear), saved);
        end
        hold = 1'b0; clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
